// File: rtl/qam64_pkg.sv
// Shared constants and the symbol-to-level mapping for the 64QAM FIFO reader.
package qam64_pkg;

  localparam int unsigned SYM_W  = 6;
  localparam int unsigned LVL_W  = 4;
  localparam int unsigned BYTE_W = 8;

  // Map a 3-bit coordinate to the odd level 2*v-7 in 4-bit two's complement.
  function automatic logic signed [LVL_W-1:0] qam64_level(input logic [2:0] v);
    logic [LVL_W-1:0] t;
    t = {v, 1'b0} - LVL_W'(7);
    return $signed(t);
  endfunction

endpackage

// File: rtl/qam64_fifo_reader_if.sv
// FIFO read port plus the upsampled I/Q stream towards the pulse-shaping filter.
interface qam64_fifo_reader_if;

  logic [qam64_pkg::BYTE_W-1:0]       fifo_data;
  logic                               fifo_empty;
  logic                               fifo_read_enable;
  logic signed [qam64_pkg::LVL_W-1:0] sym_i;
  logic signed [qam64_pkg::LVL_W-1:0] sym_q;
  logic                               sym_first;
  logic                               sym_valid;
  logic                               sym_ready;

  // Reader side: pops the FIFO and sources the symbol stream.
  modport master (
    input  fifo_data, fifo_empty, sym_ready,
    output fifo_read_enable, sym_i, sym_q, sym_first, sym_valid
  );

  // Environment side: the FIFO and the filter.
  modport slave (
    output fifo_data, fifo_empty, sym_ready,
    input  fifo_read_enable, sym_i, sym_q, sym_first, sym_valid
  );

endinterface

// File: rtl/qam64_upsampler.sv
// Zero-stuffing output stage: phase 0 carries the mapped levels, later phases carry zeros.
module qam64_upsampler
  import qam64_pkg::*;
#(
  parameter int unsigned UPS = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_load,
  input  logic signed [LVL_W-1:0] i_lvl_i,
  input  logic signed [LVL_W-1:0] i_lvl_q,
  input  logic                    i_ready,
  output logic                    o_free_c,
  output logic signed [LVL_W-1:0] o_sym_i,
  output logic signed [LVL_W-1:0] o_sym_q,
  output logic                    o_first,
  output logic                    o_valid
);

  localparam int unsigned PH_W = $clog2(UPS);

  logic [PH_W-1:0]         r_phase;
  logic                    r_valid;
  logic                    r_first;
  logic signed [LVL_W-1:0] r_i;
  logic signed [LVL_W-1:0] r_q;
  logic                    w_accept;
  logic                    w_last;

  // The stage can take a new symbol when idle or when its final phase leaves now.
  assign w_accept = r_valid & i_ready;
  assign w_last   = (r_phase == PH_W'(UPS - 1));
  assign o_free_c = !r_valid | (w_accept & w_last);

  // Phase counter and output register; everything holds while the filter stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_first <= 1'b0;
      r_phase <= '0;
      r_i     <= '0;
      r_q     <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_first <= 1'b1;
      r_phase <= '0;
      r_i     <= i_lvl_i;
      r_q     <= i_lvl_q;
    end else if (w_accept) begin
      r_first <= 1'b0;
      r_i     <= '0;
      r_q     <= '0;
      if (w_last) begin
        r_valid <= 1'b0;
        r_phase <= '0;
      end else begin
        r_phase <= r_phase + PH_W'(1);
      end
    end
  end

  assign o_sym_i = r_i;
  assign o_sym_q = r_q;
  assign o_first = r_first;
  assign o_valid = r_valid;

endmodule

// File: rtl/qam64_fifo_reader.sv
// 64QAM read side: pops FIFO bytes into a bit reservoir, cuts 6-bit symbols, maps them to I/Q.
module qam64_fifo_reader
  import qam64_pkg::*;
#(
  parameter int unsigned UPS = 4
) (
  input  logic                read_clk,
  input  logic                read_rst,
  qam64_fifo_reader_if.master bus
);

  localparam int unsigned RES_W = 14;
  localparam int unsigned CNT_W = 4;

  logic [RES_W-1:0]        r_res;
  logic [CNT_W-1:0]        r_cnt;
  logic                    r_pend;
  logic                    w_free;
  logic                    w_extract;
  logic                    w_pop;
  logic [SYM_W-1:0]        w_sym;
  logic [RES_W-1:0]        w_res_next;
  logic [CNT_W-1:0]        w_cnt_base;
  logic [CNT_W-1:0]        w_cnt_next;
  logic signed [LVL_W-1:0] w_lvl_i;
  logic signed [LVL_W-1:0] w_lvl_q;

  // Pop only when the reservoir is short of a symbol and nothing is already in flight.
  assign w_pop     = !read_rst & !bus.fifo_empty & (r_cnt < CNT_W'(SYM_W)) & !r_pend;
  assign w_extract = w_free & (r_cnt >= CNT_W'(SYM_W));
  assign w_sym     = r_res[RES_W-1 -: SYM_W];
  assign w_lvl_i   = qam64_level(w_sym[5:3]);
  assign w_lvl_q   = qam64_level(w_sym[2:0]);

  assign bus.fifo_read_enable = w_pop;

  // Reservoir update: extraction works on pre-capture bits, the captured byte lands below what remains.
  always_comb begin
    w_res_next = r_res;
    w_cnt_base = r_cnt;
    if (w_extract) begin
      w_res_next = r_res << SYM_W;
      w_cnt_base = r_cnt - CNT_W'(SYM_W);
    end
    w_cnt_next = w_cnt_base;
    if (r_pend) begin
      w_res_next = w_res_next | ({bus.fifo_data, {(RES_W - BYTE_W){1'b0}}} >> w_cnt_base);
      w_cnt_next = w_cnt_base + CNT_W'(BYTE_W);
    end
  end

  // Reservoir, bit count and in-flight read flag; reset drops any byte still on its way.
  always_ff @(posedge read_clk) begin
    if (read_rst) begin
      r_res  <= '0;
      r_cnt  <= '0;
      r_pend <= 1'b0;
    end else begin
      r_res  <= w_res_next;
      r_cnt  <= w_cnt_next;
      r_pend <= w_pop;
    end
  end

  qam64_upsampler #(
    .UPS (UPS)
  ) u_ups (
    .clk      (read_clk),
    .rst      (read_rst),
    .i_load   (w_extract),
    .i_lvl_i  (w_lvl_i),
    .i_lvl_q  (w_lvl_q),
    .i_ready  (bus.sym_ready),
    .o_free_c (w_free),
    .o_sym_i  (bus.sym_i),
    .o_sym_q  (bus.sym_q),
    .o_first  (bus.sym_first),
    .o_valid  (bus.sym_valid)
  );

endmodule

// File: tb/tb_qam64_fifo_reader.sv
// Bench for qam64_fifo_reader: FIFO model, scoreboard of hand-decoded samples, directed checks.
module tb_qam64_fifo_reader;

  localparam int unsigned UPS = 4;

  typedef struct packed {
    logic signed [3:0] i;
    logic signed [3:0] q;
    logic              first;
  } samp_t;

  logic clk = 1'b0;
  logic read_rst = 1'b1;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  int   t0;

  logic [7:0] mem [0:63];
  int   wr_ptr = 0;
  int   rd_ptr = 0;

  samp_t sb[$];

  qam64_fifo_reader_if bus ();

  qam64_fifo_reader #(
    .UPS (UPS)
  ) dut (
    .read_clk (clk),
    .read_rst (read_rst),
    .bus      (bus.master)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // FIFO model: data appears one cycle after an accepted pop.
  assign bus.fifo_empty = (rd_ptr == wr_ptr);
  always @(posedge clk) begin
    if (bus.fifo_read_enable && (rd_ptr != wr_ptr)) begin
      bus.fifo_data <= mem[rd_ptr];
      rd_ptr        <= rd_ptr + 1;
    end
  end

  // Monitor: every accepted sample is checked against the head of the scoreboard.
  initial begin
    samp_t got, exp;
    forever begin
      @(negedge clk);
      #3;
      if (bus.sym_valid && bus.sym_ready) begin
        got = '{i: bus.sym_i, q: bus.sym_q, first: bus.sym_first};
        n_tests++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_sample got i=%0d q=%0d first=%0d", got.i, got.q, got.first);
        end else begin
          exp = sb.pop_front();
          if (got !== exp) begin
            n_fail++;
            $display("FAIL sample got i=%0d q=%0d first=%0d exp i=%0d q=%0d first=%0d",
                     got.i, got.q, got.first, exp.i, exp.q, exp.first);
          end
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
    end
  endtask

  task automatic load(input logic [7:0] b);
    mem[wr_ptr] = b;
    wr_ptr      = wr_ptr + 1;
  endtask

  task automatic push_sym(input int vi, input int vq);
    sb.push_back('{i: 4'(vi), q: 4'(vq), first: 1'b1});
    for (int k = 1; k < int'(UPS); k++) sb.push_back('{i: 4'sd0, q: 4'sd0, first: 1'b0});
  endtask

  task automatic drain(input string nm);
    for (int k = 0; k < 300 && sb.size() != 0; k++) tick();
    chk(nm, sb.size(), 0);
    repeat (UPS + 2) tick();
  endtask

  task automatic chk_idle_outputs(input string nm);
    chk({nm, "_valid"}, int'(bus.sym_valid), 0);
    chk({nm, "_i"}, int'(bus.sym_i), 0);
    chk({nm, "_q"}, int'(bus.sym_q), 0);
    chk({nm, "_first"}, int'(bus.sym_first), 0);
    chk({nm, "_rd_en"}, int'(bus.fifo_read_enable), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.sym_ready = 1'b1;
    repeat (3) tick();
    chk_idle_outputs("reset");
    read_rst = 1'b0;

    // Empty FIFO from reset: no pops, no output
    repeat (10) begin
      tick();
      chk("empty_rd_en", int'(bus.fifo_read_enable), 0);
      chk("empty_valid", int'(bus.sym_valid), 0);
    end

    // Single load and first-sample latency
    push_sym(-7, -5);
    push_sym(-3, -1);
    push_sym(1, 3);
    push_sym(5, 7);
    load(8'h05); load(8'h39); load(8'h77);
    #1;
    chk("lat_pop", int'(bus.fifo_read_enable), 1);
    t0 = cyc;
    for (int k = 0; k < 10 && !bus.sym_valid; k++) tick();
    chk("latency", cyc - t0, 3);
    chk("lat_first", int'(bus.sym_first), 1);
    drain("drain_single");

    // Extremes
    repeat (4) push_sym(-7, -7);
    load(8'h00); load(8'h00); load(8'h00);
    drain("drain_zeros");
    repeat (4) push_sym(7, 7);
    load(8'hFF); load(8'hFF); load(8'hFF);
    drain("drain_ones");

    // Backpressure on the phase-0 sample of the second symbol
    push_sym(-7, 1);
    push_sym(1, -1);
    push_sym(-3, -5);
    push_sym(-3, 5);
    push_sym(-7, -5);
    push_sym(-3, -1);
    push_sym(1, 3);
    push_sym(5, 7);
    load(8'h12); load(8'h34); load(8'h56);
    load(8'h05); load(8'h39); load(8'h77);
    for (int k = 0; k < 100; k++) begin
      if (bus.sym_valid && bus.sym_first && bus.sym_i == 4'sd1 && bus.sym_q == -4'sd1) break;
      tick();
    end
    bus.sym_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) begin
        tick();
        chk("bp_no_pop", int'(bus.fifo_read_enable), 0);
      end
      chk("bp_valid", int'(bus.sym_valid), 1);
      chk("bp_i", int'(bus.sym_i), 1);
      chk("bp_q", int'(bus.sym_q), -1);
      chk("bp_first", int'(bus.sym_first), 1);
    end
    bus.sym_ready = 1'b1;
    drain("drain_bp");

    // Two bytes: two symbols, four bits retained until the next byte arrives
    push_sym(7, 5);
    push_sym(1, 3);
    load(8'hFA); load(8'h5C);
    drain("drain_partial");
    repeat (20) begin
      tick();
      chk("partial_hold", int'(bus.sym_valid), 0);
    end
    push_sym(5, -3);
    push_sym(-5, 7);
    load(8'h8F);
    drain("drain_retained");

    // Reset one cycle after a pop: the in-flight byte is dropped
    load(8'hAA); load(8'hBB); load(8'hCC);
    #1;
    chk("rst_pop", int'(bus.fifo_read_enable), 1);
    tick();
    read_rst = 1'b1;
    tick();
    chk_idle_outputs("midrst");
    push_sym(3, 5);
    push_sym(7, 1);
    read_rst = 1'b0;
    drain("drain_after_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
